// File: rtl/morph_pkg.sv
// morph_pkg
// Shared definitions for the streaming binary morphology filter:
//   mode_t  - window reduction selector (erode = AND, dilate = OR)
//   state_t - input-side control state (RUN accepts pixels, FLUSH pads)
//   calc_r / flush_len / cnt_width - constant helpers for kernel radius,
//   end-of-frame padding length and counter widths.
package morph_pkg;

  typedef enum logic {
    MODE_ERODE  = 1'b0,
    MODE_DILATE = 1'b1
  } mode_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Kernel radius: distance from the window centre to its edge.
  function automatic int calc_r(input int ksize);
    return (ksize - 1) / 2;
  endfunction

  // Number of padding cycles needed to push the last centre pixel
  // through the window once input has stopped.
  function automatic int flush_len(input int width, input int ksize);
    return calc_r(ksize) * width + calc_r(ksize);
  endfunction

  // Width of a counter covering 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer
// One-bit delay line of DEPTH stages that only moves when 'shift' is high.
// 'delayed' presents the pixel written DEPTH shifts ago, i.e. the pixel
// directly above the one currently on 'pixel' in a raster stream.
// No reset: contents are masked by the filter's border logic.
// Ports:
//   clock   in  system clock
//   shift   in  advance the delay line by one pixel
//   pixel   in  pixel entering the line
//   delayed out pixel leaving the line (DEPTH shifts old)
module line_buffer #(
  parameter int DEPTH = 640
) (
  input  logic clock,
  input  logic shift,
  input  logic pixel,
  output logic delayed
);

  logic [DEPTH-1:0] taps;

  always_ff @(posedge clock) begin
    if (shift) taps <= {taps[DEPTH-2:0], pixel};
  end

  assign delayed = taps[DEPTH-1];

endmodule

// File: rtl/morph_filter.sv
// morph_filter
// Streaming KSIZE x KSIZE binary erosion/dilation over a WIDTH x HEIGHT
// raster image. KSIZE-1 line buffers plus the live pixel form the newest
// window column; KSIZE-1 older columns are held in registers. Taps outside
// the image are forced to the neutral value, with masks computed from the
// output-centre counters. After the last input pixel the block flushes
// with neutral padding so every frame yields exactly WIDTH*HEIGHT outputs.
// Ports:
//   clock, reset_n     clock and synchronous active-low reset
//   mode               0 erode / 1 dilate, latched with pixel (0,0)
//   in_write, in_pixel input strobe and pixel (accepted with in_ready)
//   in_ready           low during the end-of-frame flush
//   out_read, out_pixel output strobe and filtered pixel
//   out_eof            marks the last output pixel of a frame
//   drop_err           sticky flag for writes attempted while not ready
module morph_filter
  import morph_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int KSIZE  = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic mode,
  input  logic in_write,
  input  logic in_pixel,
  output logic in_ready,
  output logic out_read,
  output logic out_pixel,
  output logic out_eof,
  output logic drop_err
);

  localparam int K    = KSIZE;
  localparam int R    = calc_r(KSIZE);
  localparam int FLEN = flush_len(WIDTH, KSIZE);
  localparam int CW   = cnt_width(WIDTH);
  localparam int RW   = cnt_width(HEIGHT);
  localparam int FW   = cnt_width(FLEN + 1);

  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_R      = CW'(R);
  localparam logic [RW-1:0] ROW_R      = RW'(R);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLEN - 1);

  state_t         state;
  mode_t          frame_mode;
  logic [CW-1:0]  in_col, out_col;
  logic [RW-1:0]  in_row, out_row;
  logic [FW-1:0]  flush_cnt;

  logic           accept, advance, emit, last_in, last_flush, feed, result;
  logic [K-1:0]   tap;
  logic [K-2:0]   win [K];
  logic [K-1:0]   nxt [K];
  logic [K-1:0]   row_ok, col_ok;

  assign accept     = in_write && in_ready;
  assign advance    = accept || (state == FLUSH);
  assign last_in    = accept && (in_row == ROW_LAST) && (in_col == COL_LAST);
  assign last_flush = (state == FLUSH) && (flush_cnt == FLUSH_LAST);

  // An output is due once the input has run R lines and R pixels past the
  // centre; every flush cycle also retires one centre pixel.
  assign emit = (state == FLUSH) ||
                (accept && ((in_row > ROW_R) || ((in_row == ROW_R) && (in_col >= COL_R))));

  // Padding pixels are neutral so they could never change a result even
  // if a mask were wrong.
  assign feed   = (state == FLUSH) ? (frame_mode == MODE_ERODE) : in_pixel;
  assign tap[0] = feed;

  for (genvar g = 0; g < K - 1; g++) begin : g_lines
    line_buffer #(.DEPTH(WIDTH)) u_line (
      .clock   (clock),
      .shift   (advance),
      .pixel   (tap[g]),
      .delayed (tap[g+1])
    );
  end

  // Window as it will look after this advance: the newest column is the
  // live tap set, older columns come from the registers. Row k, column c
  // holds the pixel k lines and c pixels behind the incoming one.
  always_comb begin
    for (int k = 0; k < K; k++) nxt[k] = {win[k], tap[k]};
  end

  always_ff @(posedge clock) begin
    if (advance) begin
      for (int k = 0; k < K; k++) win[k] <= nxt[k][K-2:0];
    end
  end

  // Tap (k,c) maps to image row out_row+R-k and column out_col+R-c.
  always_comb begin
    row_ok = '0;
    col_ok = '0;
    for (int k = 0; k < K; k++) begin
      row_ok[k] = (int'(out_row) + R - k >= 0) && (int'(out_row) + R - k < HEIGHT);
      col_ok[k] = (int'(out_col) + R - k >= 0) && (int'(out_col) + R - k < WIDTH);
    end
  end

  always_comb begin
    result = (frame_mode == MODE_ERODE);
    for (int k = 0; k < K; k++) begin
      for (int c = 0; c < K; c++) begin
        if (frame_mode == MODE_ERODE)
          result = result & (nxt[k][c] | ~(row_ok[k] & col_ok[c]));
        else
          result = result | (nxt[k][c] & row_ok[k] & col_ok[c]);
      end
    end
  end

  // Control FSM, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= RUN;
      in_ready   <= 1'b1;
      in_col     <= '0;
      in_row     <= '0;
      out_col    <= '0;
      out_row    <= '0;
      flush_cnt  <= '0;
      frame_mode <= MODE_ERODE;
      out_read   <= 1'b0;
      out_pixel  <= 1'b0;
      out_eof    <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      out_read  <= emit;
      out_pixel <= emit & result;
      out_eof   <= emit && (out_row == ROW_LAST) && (out_col == COL_LAST);

      if (in_write && !in_ready) drop_err <= 1'b1;

      if (accept) begin
        if ((in_row == '0) && (in_col == '0)) frame_mode <= mode_t'(mode);
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end

      if (emit) begin
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end

      unique case (state)
        RUN: begin
          if (last_in) begin
            state     <= FLUSH;
            in_ready  <= 1'b0;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          if (last_flush) begin
            state    <= RUN;
            in_ready <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_morph_filter.sv
// tb_morph_filter
// Scoreboard bench for morph_filter on an 8x8 image. Instance 0 uses a
// 3x3 kernel, instance 1 a 5x5 kernel. Each frame's expected output is
// queued when the frame is issued; a negedge monitor pops and compares
// whenever a DUT presents out_read.
module tb_morph_filter;

  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic [1:0] mode_v, in_write_v, in_pixel_v;
  logic [1:0] in_ready_v, out_read_v, out_pixel_v, out_eof_v, drop_err_v;

  morph_filter #(.WIDTH(W), .HEIGHT(H), .KSIZE(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .mode(mode_v[0]),
    .in_write(in_write_v[0]), .in_pixel(in_pixel_v[0]), .in_ready(in_ready_v[0]),
    .out_read(out_read_v[0]), .out_pixel(out_pixel_v[0]), .out_eof(out_eof_v[0]),
    .drop_err(drop_err_v[0])
  );

  morph_filter #(.WIDTH(W), .HEIGHT(H), .KSIZE(5)) dut5 (
    .clock(clock), .reset_n(reset_n), .mode(mode_v[1]),
    .in_write(in_write_v[1]), .in_pixel(in_pixel_v[1]), .in_ready(in_ready_v[1]),
    .out_read(out_read_v[1]), .out_pixel(out_pixel_v[1]), .out_eof(out_eof_v[1]),
    .drop_err(drop_err_v[1])
  );

  int         checks = 0;
  int         errors = 0;
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  int         out_count[2];
  int         low_run[2];
  int         last_low[2];
  time        first_out_t[2];
  logic       img[N];
  logic       expv[N];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: pop expected {eof,pixel} per presented output.
  always @(negedge clock) begin
    logic [1:0] e;
    for (int s = 0; s < 2; s++) begin
      if (!in_ready_v[s]) low_run[s]++;
      else if (low_run[s] != 0) begin
        last_low[s] = low_run[s];
        low_run[s]  = 0;
      end
      if (out_read_v[s]) begin
        if (first_out_t[s] == 0) first_out_t[s] = $time;
        out_count[s]++;
        if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
          check($sformatf("unexpected output dut%0d", s), 1, 0);
        end else begin
          e = (s == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("pixel dut%0d", s), int'(out_pixel_v[s]), int'(e[0]));
          check($sformatf("eof dut%0d", s), int'(out_eof_v[s]), int'(e[1]));
        end
      end
    end
  end

  // Input images: 0 all ones, 1 single zero at (3,3), 2 single one at (0,0),
  // 3 alternating columns (pixel = column bit 0).
  task automatic applyImage(input int pat);
    for (int i = 0; i < N; i++) begin
      case (pat)
        0:       img[i] = 1'b1;
        1:       img[i] = (i != 3 * W + 3);
        2:       img[i] = (i == 0);
        default: img[i] = ((i % W) % 2 == 1);
      endcase
    end
  endtask

  // Hand-derived expected results: 0 all ones, 1 all zeros, 2 zero block
  // rows 2-4 / cols 2-4, 3 ones at (0,0),(0,1),(1,0),(1,1).
  task automatic applyExpected(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       expv[i] = 1'b1;
        1:       expv[i] = 1'b0;
        2:       expv[i] = !((i / W >= 2) && (i / W <= 4) && (i % W >= 2) && (i % W <= 4));
        default: expv[i] = (i / W <= 1) && (i % W <= 1);
      endcase
    end
  endtask

  task automatic applyStimulus(input int s, input logic m0, input int toggle_at, input logic m1,
                               input int abort_at, input logic hold_flush, output time t9);
    int   idx;
    int   g;
    logic acc;
    idx = 0;
    g   = 0;
    t9  = 0;
    for (int i = 0; i < N; i++) begin
      if (s == 0) q0.push_back({i == N - 1, expv[i]});
      else        q1.push_back({i == N - 1, expv[i]});
    end
    while (idx < N && g < 2000) begin
      @(negedge clock);
      g++;
      if (idx == abort_at) begin
        in_write_v[s] = 1'b0;
        break;
      end
      mode_v[s]     = (idx >= toggle_at) ? m1 : m0;
      in_pixel_v[s] = img[idx];
      in_write_v[s] = in_ready_v[s];
      acc           = in_ready_v[s];
      @(posedge clock);
      if (acc) begin
        if (idx == 9) t9 = $time;
        idx++;
      end
    end
    if (g >= 2000) check("send timeout", 0, 1);
    if (idx == N) begin
      @(negedge clock);
      g = 0;
      while (hold_flush && !in_ready_v[s] && g < 50) begin
        in_write_v[s] = 1'b1;
        @(negedge clock);
        g++;
      end
      in_write_v[s] = 1'b0;
    end
  endtask

  task automatic checkOutput(input int s, input int count_before, input string tag);
    int g;
    g = 0;
    while (((s == 0) ? q0.size() : q1.size()) != 0 && g < 200) begin
      @(negedge clock);
      g++;
    end
    check({tag, " drained"}, (s == 0) ? q0.size() : q1.size(), 0);
    check({tag, " output count"}, out_count[s] - count_before, N);
  endtask

  task automatic checkReset();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset out_read dut%0d", s), int'(out_read_v[s]), 0);
      check($sformatf("reset out_pixel dut%0d", s), int'(out_pixel_v[s]), 0);
      check($sformatf("reset out_eof dut%0d", s), int'(out_eof_v[s]), 0);
      check($sformatf("reset drop_err dut%0d", s), int'(drop_err_v[s]), 0);
      check($sformatf("reset in_ready dut%0d", s), int'(in_ready_v[s]), 1);
    end
  endtask

  initial begin
    time t9;
    int  c0;
    reset_n    = 1'b0;
    mode_v     = '0;
    in_write_v = '0;
    in_pixel_v = '0;
    for (int s = 0; s < 2; s++) begin
      out_count[s]   = 0;
      low_run[s]     = 0;
      last_low[s]    = 0;
      first_out_t[s] = 0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkReset();
    reset_n = 1'b1;

    // All-ones frame, erode: latency, flush length, count, eof, no drop.
    applyImage(0);
    applyExpected(0);
    c0 = out_count[0];
    applyStimulus(0, 1'b0, N, 1'b0, -1, 1'b0, t9);
    checkOutput(0, c0, "all ones");
    check("first output latency", int'(first_out_t[0] - t9), 5);
    check("flush ready-low cycles", last_low[0], 9);
    check("drop_err after clean frame", int'(drop_err_v[0]), 0);

    // Single zero, erode.
    applyImage(1);
    applyExpected(2);
    c0 = out_count[0];
    applyStimulus(0, 1'b0, N, 1'b0, -1, 1'b0, t9);
    checkOutput(0, c0, "erode zero");

    // Single one, dilate.
    applyImage(2);
    applyExpected(3);
    c0 = out_count[0];
    applyStimulus(0, 1'b1, N, 1'b1, -1, 1'b0, t9);
    checkOutput(0, c0, "dilate one");

    // Alternating columns, erode, 3x3.
    applyImage(3);
    applyExpected(1);
    c0 = out_count[0];
    applyStimulus(0, 1'b0, N, 1'b0, -1, 1'b0, t9);
    checkOutput(0, c0, "alt erode k3");

    // Mode toggled at pixel 20: this frame stays erode, next one dilates.
    applyImage(1);
    applyExpected(2);
    c0 = out_count[0];
    applyStimulus(0, 1'b0, 20, 1'b1, -1, 1'b0, t9);
    checkOutput(0, c0, "toggle frame");
    applyExpected(0);
    c0 = out_count[0];
    applyStimulus(0, 1'b1, N, 1'b1, -1, 1'b0, t9);
    checkOutput(0, c0, "after toggle");

    // Writes held during flush are dropped and flagged.
    applyImage(0);
    applyExpected(0);
    c0 = out_count[0];
    applyStimulus(0, 1'b0, N, 1'b0, -1, 1'b1, t9);
    checkOutput(0, c0, "drop frame");
    check("drop_err set", int'(drop_err_v[0]), 1);

    // Reset at pixel 30 abandons the frame.
    applyImage(1);
    applyExpected(2);
    applyStimulus(0, 1'b0, N, 1'b0, 30, 1'b0, t9);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    q0.delete();
    checkReset();
    reset_n = 1'b1;

    // Clean frame after reset.
    c0 = out_count[0];
    applyStimulus(0, 1'b0, N, 1'b0, -1, 1'b0, t9);
    checkOutput(0, c0, "post reset");

    // 5x5 kernel on alternating columns.
    applyImage(3);
    applyExpected(0);
    c0 = out_count[1];
    applyStimulus(1, 1'b1, N, 1'b1, -1, 1'b0, t9);
    checkOutput(1, c0, "alt dilate k5");
    applyExpected(1);
    c0 = out_count[1];
    applyStimulus(1, 1'b0, N, 1'b0, -1, 1'b0, t9);
    checkOutput(1, c0, "alt erode k5");
    check("flush ready-low cycles k5", last_low[1], 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/morph_filter.md
Name: morph_filter

Overview:
Streaming binary morphological filter: square KSIZE x KSIZE erosion or dilation over a raster-scan 1-bit image of WIDTH x HEIGHT pixels. Generalises the fixed 3x3 erosion stage in the sensor pipeline with a run-time mode, a parametrised kernel, defined border handling and an end-of-frame flush. It sits between the binarisation/threshold stage and the blob/centroid stage, and uses the same write/read strobe style.

Parameters:
WIDTH, 640, pixels per line (>= KSIZE)
HEIGHT, 480, lines per frame (>= KSIZE)
KSIZE, 3, kernel side; odd, 3..7; R = (KSIZE-1)/2

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
mode  in  1  0 = erode (AND of window), 1 = dilate (OR of window); sampled at frame start
in_write  in  1  input pixel strobe; pixel accepted when in_write && in_ready
in_pixel  in  1  input pixel, raster order
in_ready  out  1  0 while flushing; writes while low are dropped
out_read  out  1  output pixel strobe (valid)
out_pixel  out  1  filtered pixel, raster order
out_eof  out  1  pulses with the last output pixel of a frame
drop_err  out  1  sticky; set when in_write is asserted while in_ready=0; cleared by reset

Behaviour:
- Reset (clock edge with reset_n=0): out_read=0, out_pixel=0, out_eof=0, drop_err=0, in_ready=1. Counters go to 0 and state to RUN. Line-buffer contents are don't-care, masked by the border logic. Reset mid-frame abandons the frame; the next accepted pixel is (0,0).
- The clock is assumed to run continuously. There is no output backpressure; the downstream stage must accept one pixel per cycle.
- Input row/column counters advance on each accepted pixel and wrap at WIDTH-1 / HEIGHT-1.
- mode is latched when pixel (0,0) is accepted. Changes mid-frame take effect on the next frame.
- Window: KSIZE rows from KSIZE-1 line buffers plus the live input, shifted into a KSIZE x KSIZE register array.
- Border handling:
  - Window taps whose image coordinates fall outside 0..HEIGHT-1 / 0..WIDTH-1 are replaced by the neutral value: 1 for erode, 0 for dilate.
  - Borders therefore never erode or dilate inward.
  - Masks are derived from the output-centre row/column counters, never from buffer contents.
- Latency:
  - Output pixel n (raster index) is produced once the window holds it fully.
  - The trigger is acceptance of input pixel n + R*WIDTH + R, or the equivalent flush cycle.
  - out_read and out_pixel are registered and assert on the clock after the trigger.
- States:
  - RUN:
    - in_ready=1.
    - After accepting pixel (HEIGHT-1, WIDTH-1), go to FLUSH.
  - FLUSH:
    - in_ready=0.
    - Generates R*WIDTH+R internal padding cycles, one per clock.
    - Each cycle advances the pipeline as an accepted neutral pixel would.
    - Returns to RUN on the cycle in which the last output (index WIDTH*HEIGHT-1) is produced.
    - in_ready=1 on the following cycle.
- Exactly WIDTH*HEIGHT outputs per frame. out_eof is coincident with the out_read of index WIDTH*HEIGHT-1.
- Output centre counters wrap with the frame. Back-to-back frames need no gap beyond the FLUSH period.
- Arithmetic:
  - Counters are $clog2(WIDTH) / $clog2(HEIGHT) bits.
  - Flush counter is $clog2(R*WIDTH+R+1) bits.
  - The reduction is a pure KSIZE*KSIZE-input AND/OR.

Decomposition:
- morph_pkg: mode encodings (MODE_ERODE=0, MODE_DILATE=1), state encoding (RUN, FLUSH), and the R / flush-length / counter-width constant functions.
- Sub-module line_buffer: 1-bit, WIDTH-deep delay line with a shift enable, instantiated KSIZE-1 times; maps to M9K RAM or shift registers.
- Window, masking, reduction and FSM stay in morph_filter.

Test Plan:
Setup for all cases: WIDTH=8, HEIGHT=8, KSIZE=3, in_write held 1 whenever in_ready=1.
- Latency/flush:
  - All-ones frame in erode mode: first out_read on the cycle after the 10th accepted pixel.
  - in_ready low for exactly 9 cycles after the 64th pixel.
  - 64 outputs, all 1.
  - out_eof on output 63; drop_err stays 0.
- Erode, single zero at (3,3), all other pixels 1 -> zeros exactly at rows 2-4, cols 2-4 (9 zeros); 55 ones.
- Dilate, single one at (0,0) -> ones at (0,0),(0,1),(1,0),(1,1) only; no wrap artefacts at (0,7) or (7,0).
- Alternating columns (pixel = column[0]) -> erode gives all 0. Repeat with KSIZE=5: dilate gives all 1, erode gives all 0.
- mode toggled at pixel 20 of a frame -> that frame is unaffected; the next frame uses the new mode.
- Control/reset events:
  - in_write held during FLUSH -> drop_err=1 and output count unchanged.
  - reset_n=0 for 1 cycle at pixel 30 -> outputs reset to 0.
  - A clean frame after reset matches the expected result exactly.
